// File: rtl/debug_probe_pkg.sv
// Shared types for the debug probe mux: FSM state encoding and
// the channel-index width helper.
package debug_probe_pkg;

    typedef enum logic [1:0] {
        ST_LIVE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_FROZEN = 2'd2
    } state_e;

    function automatic int ch_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debug_probe_mux_scan_timer.sv
// Auto-scan dwell timer: holds each channel index for SCAN_DIV
// cycles, wrapping after the last valid channel; idle at 0 when disabled.
module scan_timer #(
    parameter int SCAN_DIV = 50_000_000,
    parameter int N_VALID  = 11,
    parameter int IDX_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [IDX_W-1:0] idx
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (!en) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (cnt_q == DW'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(N_VALID - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign idx = idx_q;

endmodule

// File: rtl/debug_probe_mux.sv
// Debug probe mux: live/armed/frozen snapshot viewer with auto-scan.
// Optional DEBUG_PROBE_LATENCY_CNT_EN adds an arm-to-trigger latency channel.
module debug_probe_mux
    import debug_probe_pkg::*;
#(
    parameter int  N_CH     = 11,
    parameter int  DATA_W   = 32,
    parameter int  DISP_W   = 13,
    parameter int  SCAN_DIV = 50_000_000,
    localparam int CH_W     = ch_w(N_CH)
) (
    input  logic                   rclk,
    input  logic                   rst,
    input  logic [N_CH*DATA_W-1:0] probe_bus,
    input  logic [CH_W-1:0]        sel,
    input  logic                   auto_en,
    input  logic                   arm,
    input  logic                   capture,
    input  logic                   release_i,
    input  logic [CH_W-1:0]        trig_ch,
    input  logic [DATA_W-1:0]      trig_val,
    output logic [DISP_W-1:0]      disp_val,
    output logic [CH_W-1:0]        disp_ch,
    output logic                   frozen,
    output logic                   armed,
    output logic                   ovf,
    output logic                   sel_err
);

`ifdef DEBUG_PROBE_LATENCY_CNT_EN
    localparam int NV = N_CH + 1;
`else
    localparam int NV = N_CH;
`endif

    state_e state_q, state_d;

    logic [DATA_W-1:0] probe  [N_CH];
    logic [DATA_W-1:0] snap_q [N_CH];
    logic [DATA_W-1:0] snap_d [N_CH];

    logic [DISP_W-1:0] disp_val_q, disp_val_d;
    logic [CH_W-1:0]   disp_ch_q, disp_ch_d;
    logic              ovf_q, ovf_d;
    logic              sel_err_q, sel_err_d;

    logic              trig_hit;
    logic              enter_frz;
    logic [CH_W-1:0]   scan_idx;
    logic [CH_W-1:0]   ch;
    logic              ch_ok;
    logic [DATA_W-1:0] src;

    for (genvar k = 0; k < N_CH; k++) begin : g_probe
        assign probe[k] = probe_bus[k*DATA_W +: DATA_W];
    end

    scan_timer #(
        .SCAN_DIV (SCAN_DIV),
        .N_VALID  (NV),
        .IDX_W    (CH_W)
    ) u_scan (
        .clk   (rclk),
        .rst_n (rst),
        .en    (auto_en),
        .idx   (scan_idx)
    );

    // Out-of-range trig_ch matches no channel, so it can never fire.
    always_comb begin
        trig_hit = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (trig_ch == CH_W'(k) && probe[k] == trig_val) begin
                trig_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LIVE: begin
                if (capture) state_d = ST_FROZEN;
                else if (arm) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (capture || trig_hit) state_d = ST_FROZEN;
            end
            ST_FROZEN: begin
                if (release_i) state_d = ST_LIVE;
            end
            default: state_d = ST_LIVE;
        endcase
    end

    assign enter_frz = (state_q != ST_FROZEN) && (state_d == ST_FROZEN);

    always_comb begin
        snap_d = snap_q;
        if (enter_frz) snap_d = probe;
    end

`ifdef DEBUG_PROBE_LATENCY_CNT_EN
    logic [DATA_W-1:0] lat_q, lat_d;
    logic [DATA_W-1:0] lat_snap_q, lat_snap_d;

    always_comb begin
        lat_d = lat_q;
        if (state_q == ST_ARMED) begin
            lat_d = (lat_q == '1) ? lat_q : lat_q + 1'b1;
        end else if (state_q == ST_LIVE && state_d == ST_ARMED) begin
            lat_d = '0;
        end
        lat_snap_d = enter_frz ? lat_d : lat_snap_q;
    end

    always_ff @(posedge rclk or negedge rst) begin
        if (!rst) begin
            lat_q      <= '0;
            lat_snap_q <= '0;
        end else begin
            lat_q      <= lat_d;
            lat_snap_q <= lat_snap_d;
        end
    end
`endif

    assign ch    = auto_en ? scan_idx : sel;
    assign ch_ok = {1'b0, ch} < (CH_W+1)'(NV);

    always_comb begin
        src = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch == CH_W'(k)) begin
                src = (state_q == ST_FROZEN) ? snap_q[k] : probe[k];
            end
        end
`ifdef DEBUG_PROBE_LATENCY_CNT_EN
        if (ch == CH_W'(N_CH)) begin
            src = (state_q == ST_FROZEN) ? lat_snap_q : lat_q;
        end
`endif
    end

    always_comb begin
        disp_val_d = '0;
        disp_ch_d  = '0;
        ovf_d      = 1'b0;
        sel_err_d  = 1'b1;
        if (ch_ok) begin
            disp_val_d = src[DISP_W-1:0];
            disp_ch_d  = ch;
            ovf_d      = (src >> DISP_W) != '0;
            sel_err_d  = 1'b0;
        end
    end

    always_ff @(posedge rclk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_LIVE;
            disp_val_q <= '0;
            disp_ch_q  <= '0;
            ovf_q      <= 1'b0;
            sel_err_q  <= 1'b0;
            for (int k = 0; k < N_CH; k++) snap_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            disp_val_q <= disp_val_d;
            disp_ch_q  <= disp_ch_d;
            ovf_q      <= ovf_d;
            sel_err_q  <= sel_err_d;
            snap_q     <= snap_d;
        end
    end

    assign disp_val = disp_val_q;
    assign disp_ch  = disp_ch_q;
    assign ovf      = ovf_q;
    assign sel_err  = sel_err_q;
    assign frozen   = (state_q == ST_FROZEN);
    assign armed    = (state_q == ST_ARMED);

endmodule

// File: tb/tb_debug_probe_mux.sv
// Randomized + directed bench for debug_probe_mux against a
// cycle-level behavioural model of the viewer.
module tb_debug_probe_mux;

    localparam int N_CH     = 4;
    localparam int DATA_W   = 32;
    localparam int DISP_W   = 13;
    localparam int SCAN_DIV = 3;
    localparam int CH_W     = debug_probe_pkg::ch_w(N_CH);
`ifdef DEBUG_PROBE_LATENCY_CNT_EN
    localparam int NV = N_CH + 1;
`else
    localparam int NV = N_CH;
`endif

    logic                   rclk;
    logic                   rst;
    logic [N_CH*DATA_W-1:0] probe_bus;
    logic [CH_W-1:0]        sel;
    logic                   auto_en;
    logic                   arm;
    logic                   capture;
    logic                   release_i;
    logic [CH_W-1:0]        trig_ch;
    logic [DATA_W-1:0]      trig_val;
    logic [DISP_W-1:0]      disp_val;
    logic [CH_W-1:0]        disp_ch;
    logic                   frozen;
    logic                   armed;
    logic                   ovf;
    logic                   sel_err;

    logic [DATA_W-1:0] pv [N_CH];

    always_comb begin
        probe_bus = '0;
        for (int k = 0; k < N_CH; k++) probe_bus[k*DATA_W +: DATA_W] = pv[k];
    end

    debug_probe_mux #(
        .N_CH     (N_CH),
        .DATA_W   (DATA_W),
        .DISP_W   (DISP_W),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .rclk      (rclk),
        .rst       (rst),
        .probe_bus (probe_bus),
        .sel       (sel),
        .auto_en   (auto_en),
        .arm       (arm),
        .capture   (capture),
        .release_i (release_i),
        .trig_ch   (trig_ch),
        .trig_val  (trig_val),
        .disp_val  (disp_val),
        .disp_ch   (disp_ch),
        .frozen    (frozen),
        .armed     (armed),
        .ovf       (ovf),
        .sel_err   (sel_err)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int n_chk;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: mode flags, snapshots, latency count, auto-run length.
    bit          m_frz, m_arm;
    logic [31:0] m_snap [N_CH];
    logic [31:0] m_lat, m_lat_snap;
    int          m_run;
    logic [31:0] e_val, e_ch;
    bit          e_ovf, e_err;

    function automatic logic [31:0] sat1(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    function automatic logic [31:0] chan_val(input int c);
        if (c < N_CH) return m_frz ? m_snap[c] : pv[c];
        return m_frz ? m_lat_snap : m_lat;
    endfunction

    task automatic model_reset();
        m_frz = 0; m_arm = 0; m_lat = 0; m_lat_snap = 0; m_run = 0;
        for (int k = 0; k < N_CH; k++) m_snap[k] = 0;
        e_val = 0; e_ch = 0; e_ovf = 0; e_err = 0;
    endtask

    task automatic check_outs(input string ph);
        chk({ph, ".val"}, 32'(disp_val), e_val);
        chk({ph, ".ch"}, 32'(disp_ch), e_ch);
        chk({ph, ".ovf"}, 32'(ovf), 32'(e_ovf));
        chk({ph, ".err"}, 32'(sel_err), 32'(e_err));
        chk({ph, ".frz"}, 32'(frozen), 32'(m_frz));
        chk({ph, ".arm"}, 32'(armed), 32'(m_arm));
    endtask

    // One clock: predict from current inputs, step model, check, clear pulses.
    task automatic cycle(input string ph);
        int          c;
        logic [31:0] v;
        bit          hit;
        c = auto_en ? (m_run / SCAN_DIV) % NV : int'(sel);
        if (c < NV) begin
            v = chan_val(c);
            e_val = v % (32'd1 << DISP_W);
            e_ch = c;
            e_ovf = (v >> DISP_W) != 0;
            e_err = 0;
        end else begin
            e_val = 0; e_ch = 0; e_ovf = 0; e_err = 1;
        end
        hit = int'(trig_ch) < N_CH && pv[int'(trig_ch) % N_CH] == trig_val;
        if (m_frz) begin
            if (release_i) m_frz = 0;
        end else if (capture || (m_arm && hit)) begin
            if (m_arm) m_lat = sat1(m_lat);
            m_lat_snap = m_lat;
            for (int k = 0; k < N_CH; k++) m_snap[k] = pv[k];
            m_frz = 1; m_arm = 0;
        end else if (m_arm) begin
            m_lat = sat1(m_lat);
        end else if (arm) begin
            m_arm = 1; m_lat = 0;
        end
        m_run = auto_en ? m_run + 1 : 0;
        @(posedge rclk);
        #1;
        check_outs(ph);
        arm = 0; capture = 0; release_i = 0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_outs("rst_async");
        @(posedge rclk);
        #1;
        check_outs("rst_hold");
        rst = 1'b1;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b0;
        sel = '0; auto_en = 0; arm = 0; capture = 0; release_i = 0;
        trig_ch = '0; trig_val = '0;
        for (int k = 0; k < N_CH; k++) pv[k] = '0;
        model_reset();
        #1;
        check_outs("por");
        @(posedge rclk);
        #1;
        rst = 1'b1;

        // Reset while ARMED and auto-scanning.
        for (int k = 0; k < N_CH; k++) pv[k] = 32'h100 + k;
        auto_en = 1; trig_ch = 3'd1; trig_val = 32'hDEAD;
        arm = 1;
        cycle("r36a");
        cycle("r36b");
        chk("r36_armed", 32'(armed), 32'd1);
        do_reset();
        cycle("r36c");
        chk("r36_live", 32'(armed | frozen), 32'd0);

        // Auto-scan sequence from a fresh start.
        do_reset();
        auto_en = 0;
        cycle("r37pre");
        auto_en = 1;
        for (int i = 0; i < 13; i++) begin
            cycle("r37");
            chk("r37_seq", 32'(disp_ch), 32'((i / SCAN_DIV) % NV));
        end
        auto_en = 0;

        // Trigger on a ramp, then release.
        do_reset();
        sel = 3'd2; trig_ch = 3'd2; trig_val = 32'd5; pv[2] = 0;
        arm = 1;
        cycle("r38arm");
        for (int r = 0; r < 10; r++) begin
            pv[2] = r;
            cycle("r38");
            chk("r38_frz", 32'(frozen), 32'(r >= 5));
            chk("r38_val", 32'(disp_val), 32'((r >= 5) ? 5 : r));
        end
        release_i = 1;
        cycle("r38rel");
        chk("r38_live", 32'(frozen), 32'd0);
        cycle("r38post");
        chk("r38_liveval", 32'(disp_val), 32'd9);

        // Overflow and invalid select.
        sel = 3'd1; pv[1] = 32'h0000_2001;
        cycle("r39a");
        chk("r39_val", 32'(disp_val), 32'h1);
        chk("r39_ovf", 32'(ovf), 32'd1);
        sel = 3'd7;
        cycle("r39b");
        chk("r39_err", 32'(sel_err), 32'd1);
        chk("r39_zero", 32'(disp_val), 32'd0);
        sel = 3'(N_CH);
        cycle("r39c");
        chk("r39_nch", 32'(sel_err), 32'(NV == N_CH));

        // arm + capture together; armed must stay low.
        do_reset();
        arm = 1; capture = 1;
        cycle("r40a");
        chk("r40_frz", 32'(frozen), 32'd1);
        chk("r40_arm", 32'(armed), 32'd0);
        arm = 1;
        cycle("r40b");
        chk("r40_ign", 32'(armed), 32'd0);
        release_i = 1;
        cycle("r40rel");
`ifdef DEBUG_PROBE_LATENCY_CNT_EN
        trig_ch = 3'd0; trig_val = 32'hCAFE; pv[0] = 32'h1;
        arm = 1;
        cycle("r40c");
        for (int i = 0; i < 5; i++) cycle("r40w");
        pv[0] = 32'hCAFE;
        cycle("r40m");
        sel = 3'(N_CH);
        cycle("r40d");
        chk("r40_lat", 32'(disp_val), 32'd6);
        release_i = 1;
        cycle("r40e");
`endif

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < N_CH; k++)
                pv[k] = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 8191);
            if ($urandom_range(0, 39) == 0) auto_en = ~auto_en;
            sel = CH_W'($urandom);
            trig_ch = CH_W'($urandom);
            trig_val = $urandom_range(0, 1) ? pv[int'(trig_ch) % N_CH] : $urandom;
            arm = $urandom_range(0, 9) == 0;
            capture = $urandom_range(0, 29) == 0;
            release_i = $urandom_range(0, 7) == 0;
            if ($urandom_range(0, 149) == 0) do_reset();
            else cycle("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_probe_mux.md
DEBUG_PROBE_MUX -- requirements
Module: debug_probe_mux

Interface
REQ-001 SHALL have parameter N_CH, default 11, number of probe channels.
REQ-002 SHALL have parameter DATA_W, default 32, width of each probe channel.
REQ-003 SHALL have parameter DISP_W, default 13, width of display value.
REQ-004 SHALL have parameter SCAN_DIV, default 50_000_000, rclk cycles per auto-scan dwell.
REQ-005 SHALL have one clock; reset is asynchronous and active-low.
REQ-006 rclk  input  1  sole clock, rising edge.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 probe_bus  input  N_CH*DATA_W  live probe values; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-009 sel  input  CH_W (= clog2(N_CH+1))  manual channel select.
REQ-010 auto_en  input  1  level; 1 = auto-scan channels.
REQ-011 arm  input  1  one-cycle pulse; arm trigger.
REQ-012 capture  input  1  one-cycle pulse; force snapshot.
REQ-013 release  input  1  one-cycle pulse; leave frozen state.
REQ-014 trig_ch  input  CH_W  channel compared for trigger.
REQ-015 trig_val  input  DATA_W  trigger match value.
REQ-016 disp_val  output  DISP_W  registered display value.
REQ-017 disp_ch  output  CH_W  registered index of displayed channel.
REQ-018 frozen  output  1  1 while snapshot is displayed.
REQ-019 armed  output  1  1 while awaiting trigger.
REQ-020 ovf  output  1  1 when displayed channel has nonzero bits above DISP_W-1.
REQ-021 sel_err  output  1  1 when manual sel >= number of valid channels.

Function
REQ-022 FSM states LIVE, ARMED, FROZEN SHALL be encoded; LIVE -arm-> ARMED; ARMED -(probe[trig_ch]==trig_val)-> FROZEN; LIVE/ARMED -capture-> FROZEN; FROZEN -release-> LIVE; all other inputs hold state.
REQ-023 On entry to FROZEN all N_CH channels SHALL be latched into snapshot registers in the same edge as the transition, using probe_bus values of the transition cycle.
REQ-024 Display source SHALL be probe_bus in LIVE/ARMED and snapshot registers in FROZEN.
REQ-025 disp_val/disp_ch/ovf/sel_err SHALL have exactly one rclk latency from source data and channel index.
REQ-026 Manual mode: channel = sel; if sel invalid, disp_val = 0, disp_ch = 0, sel_err = 1.
REQ-027 Auto-scan: channel index SHALL advance every SCAN_DIV cycles, wrapping from last valid channel to 0; dwell counter and index SHALL reset to 0 when auto_en falls.
REQ-028 arm and capture same cycle: capture wins (FROZEN). release and trigger match same cycle in ARMED: no effect of release, match wins. release outside FROZEN is ignored; arm in ARMED/FROZEN ignored.
REQ-029 trig_ch >= N_CH SHALL never match.
REQ-030 frozen = (state==FROZEN); armed = (state==ARMED); both combinational from state register.

Reset
REQ-031 rst low SHALL asynchronously force state LIVE, snapshot registers 0, scan index and dwell counter 0, disp_val 0, disp_ch 0, ovf 0, sel_err 0, frozen 0, armed 0, including mid-scan or mid-ARMED.

Configuration
REQ-032 Macro DEBUG_PROBE_LATENCY_CNT_EN defined: a DATA_W-bit saturating counter SHALL clear on arm, count each ARMED cycle, be latched on entry to FROZEN, and appear as extra channel index N_CH (valid channels = N_CH+1, included in auto-scan).
REQ-033 Macro undefined: no counter logic; valid channels = N_CH; sel = N_CH SHALL raise sel_err.

Structure
REQ-034 Package debug_probe_pkg SHALL hold the FSM state enum and the CH_W width function.
REQ-035 Sub-module scan_timer SHALL implement the SCAN_DIV dwell counter and wrapping index.

Verification
REQ-036 Reset while ARMED with auto_en=1 -> next cycle all outputs 0, state LIVE.
REQ-037 N_CH=4, SCAN_DIV=3, auto_en=1 -> disp_ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0 (one-cycle offset).
REQ-038 arm, trig_ch=2, probe ch2 ramps 0..9, trig_val=5 -> frozen=1 the edge after ch2=5; disp_val of ch2 stays 5 as ramp continues; release -> live again.
REQ-039 sel=1, ch1=32'h0000_2001 -> disp_val=13'h0001, ovf=1; sel=7 with N_CH=4 -> disp_val=0, sel_err=1.
REQ-040 arm and capture same cycle -> FROZEN, armed never 1; with macro, arm then match after 6 ARMED cycles -> channel N_CH shows 6.
